// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding for pipeline skid stages.
//   Imported by pipe_skid_stage and by the IF/ID, ID/EX, EX/MEM and
//   MEM/WB stage wrappers that build on it.
//   The EMPTY/ONE/FULL encoding equals the number of held entries, so a
//   state value can be presented directly as an occupancy count.
package pipe_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] pipe_state_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry valid/ready skid buffer with registered outputs.
//   Parameters:
//     WIDTH     payload width in bits (1..1024)
//     RST_DATA  value loaded into the main and skid registers on reset
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     flush      synchronous kill of all held entries, highest priority
//     in_valid   upstream presents in_data
//     in_ready   stage can accept a payload (flop)
//     in_data    upstream payload
//     out_valid  stage presents out_data (flop)
//     out_ready  downstream accepts out_data
//     out_data   presented payload (main register)
//     occupancy  number of held entries, 0..2 (state register)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_t      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    pipe_state_t      w_next_state;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // Both fires are suppressed by flush so no transfer is counted that cycle.
    assign w_in_fire  = in_valid & r_in_ready & ~flush;
    assign w_out_fire = r_out_valid & out_ready & ~flush;

    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    w_load_main  = w_in_fire;
                    w_next_state = w_in_fire ? ST_ONE : ST_EMPTY;
                end
                ST_ONE: begin
                    // Push+pop replaces main; push alone parks the new word in skid.
                    w_load_main  = w_in_fire & w_out_fire;
                    w_load_skid  = w_in_fire & ~w_out_fire;
                    w_next_state = (w_in_fire & ~w_out_fire) ? ST_FULL :
                                   (~w_in_fire & w_out_fire) ? ST_EMPTY : ST_ONE;
                end
                ST_FULL: begin
                    w_load_main      = w_out_fire;
                    w_main_from_skid = 1'b1;
                    w_next_state     = w_out_fire ? ST_ONE : ST_FULL;
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // in_ready/out_valid are registered copies of the next-state decode, so
    // no output depends combinationally on any input. in_ready resets low and
    // rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_main      <= RST_DATA;
            r_skid      <= RST_DATA;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_FULL);
            r_out_valid <= (w_next_state != ST_EMPTY);
            if (w_load_main)
                r_main <= w_main_from_skid ? r_skid : in_data;
            if (w_load_skid)
                r_skid <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    // State encoding equals the entry count.
    assign occupancy = r_state;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1 to 1024.
REQ-002 Parameter RST_DATA, default 0: value loaded into both payload registers on reset; width WIDTH.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous kill of all held entries; highest priority.
REQ-006 in_valid  input  1  upstream presents a payload.
REQ-007 in_ready  output  1  stage can accept a payload; driven directly from a flop.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  stage presents a payload downstream; driven directly from a flop.
REQ-010 out_ready  input  1  downstream accepts the presented payload.
REQ-011 out_data  output  WIDTH  presented payload; driven directly from the main register.
REQ-012 occupancy  output  2  number of held entries, 0 to 2.

Function
REQ-013 The stage SHALL hold a main register and a skid register, with states EMPTY (0 entries), ONE (main valid) and FULL (main and skid valid).
REQ-014 The stage SHALL define in_fire = in_valid & in_ready & !flush and out_fire = out_valid & out_ready & !flush.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; out_valid SHALL be 0 in EMPTY and 1 otherwise.
REQ-016 EMPTY, in_fire: main <= in_data, next state ONE.
REQ-017 ONE, in_fire and out_fire: main <= in_data, state stays ONE.
REQ-018 ONE, in_fire only: skid <= in_data, next state FULL.
REQ-019 ONE, out_fire only: next state EMPTY; main is not cleared.
REQ-020 FULL, out_fire: main <= skid, next state ONE; in_valid is ignored because in_ready is 0.
REQ-021 All other combinations SHALL hold state and data.
REQ-022 When out_valid=1 and out_ready=0, out_data SHALL remain stable until out_fire or flush.
REQ-023 Latency SHALL be 1 cycle from in_fire to out_valid when the stage is EMPTY.
REQ-024 Sustained throughput SHALL be 1 payload per cycle while out_ready=1.
REQ-025 Payload order SHALL be strictly FIFO with no loss and no duplication.
REQ-026 flush=1 SHALL force the next state to EMPTY regardless of state, in_valid or out_ready, and no transfer is counted that cycle.
REQ-027 flush SHALL NOT alter the data registers.
REQ-028 in_ready SHALL be 1 in the cycle after a flush.
REQ-029 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.
REQ-030 The outputs SHALL NOT have a combinational path from any input.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state EMPTY, in_ready=0, out_valid=0 and occupancy=0, and load main and skid with RST_DATA.
REQ-032 in_ready SHALL rise to 1 on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all held entries without emitting any partial handshake.

Structure
REQ-034 The state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) SHALL be defined as localparams in shared package pipe_pkg, so it can be reused by the IF/ID, ID/EX, EX/MEM and MEM/WB instances.
REQ-035 The block SHALL be a single flat module with no sub-modules.
REQ-036 Pipeline stage wrappers SHALL concatenate their fields into in_data and out_data.

Verification
REQ-037 Reset then streaming: WIDTH=32, out_ready=1, inputs 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 on the next three cycles, occupancy stays 1.
REQ-038 Backpressure fill: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; out_ready=1 -> 0xA then 0xB, then EMPTY.
REQ-039 Flush in FULL: state FULL with 0xA and 0xB, flush=1 with in_valid=1 and data 0xC -> next cycle occupancy 0, out_valid=0, in_ready=1, and 0xC is never emitted.
REQ-040 Simultaneous push and pop in ONE: main=0x5, in_data=0x6, out_ready=1 -> out_data=0x6, occupancy 1.
REQ-041 Asynchronous reset mid-stream: rst_n low between edges while FULL -> out_valid=0 and in_ready=0 immediately, out_data=RST_DATA, in_ready=1 one edge after release.
REQ-042 Random valid/ready over 10k cycles with a scoreboard -> FIFO order exact, no output changes while stalled, occupancy never exceeds 2.
